// File: rtl/riscv_uart_pkg.sv
// Shared types and constants for the RISC-V console UART.
package riscv_uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    // Store address of the data-memory print port, also decoded by the memory/IO decoder.
    localparam logic [31:0] UART_PRINT_ADDR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/riscv_uart_fifo.sv
// Synchronous FIFO with extra-MSB pointer wrap; a push is allowed into a full FIFO
// when a pop happens in the same cycle.
module riscv_uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CW-1:0]    count_c
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_c = (wr_ptr == rd_ptr);
    assign count_c = CW'(wr_ptr - rd_ptr);
    assign rdata_c = mem[rd_ptr[AW-1:0]];

    assign do_push = push && (!full_c || pop);
    assign do_pop  = pop && !empty_c;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_uart_tx.sv
// Console UART transmitter: buffers print-port character strobes and sends them as 8N1.
module riscv_uart_tx
    import riscv_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          io_valid,
    input  logic [7:0]    io_data,
    output logic          tx,
    output logic          busy,
    output logic          overflow,
    output logic [CW-1:0] fifo_count
);

    localparam int unsigned BW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0]    BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      overflow_q;
    logic                      pop_c;
    logic [7:0]                fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;

    riscv_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (io_valid),
        .pop     (pop_c),
        .wdata   (io_data),
        .rdata_c (fifo_rdata),
        .full_c  (fifo_full),
        .empty_c (fifo_empty),
        .count_c (fifo_count)
    );

    // Next-state, baud/bit counters, shift register and the value tx takes next cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_c   = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = BAUD_MAX;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_MAX;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_rdata;
                        baud_d  = BAUD_MAX;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            if (io_valid && fifo_full && !pop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || (fifo_count != CW'(0));

endmodule

// File: tb/tb_riscv_uart_tx.sv
// Scoreboard bench for riscv_uart_tx: a frame-level reference model predicts accepted
// bytes and frame start times; a UART receiver monitor checks tx against them.
module tb_riscv_uart_tx;

    localparam int C     = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       io_valid;
    logic [7:0] io_data;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [4:0] fifo_count;

    riscv_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_valid   (io_valid),
        .io_data    (io_data),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    logic [7:0] q[$];
    frame_t     frame_q[$];
    int         t        = 0;
    int         last_pop = -100000;
    bit         ovf_m    = 1'b0;
    int         n_checks = 0;
    int         n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    // Reference model: the line is free FRAME cycles after the last pop; a waiting byte
    // is popped at the first edge the line is free; a strobe is kept if there was room
    // or a pop happened at the same edge.
    int     m_sz;
    bit     m_pop;
    frame_t m_f;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            frame_q.delete();
            last_pop = -100000;
            ovf_m    = 1'b0;
        end else begin
            t++;
            m_sz  = q.size();
            m_pop = (m_sz != 0) && (t >= last_pop + FRAME);
            if (m_pop) begin
                m_f.data  = q.pop_front();
                m_f.start = t;
                frame_q.push_back(m_f);
                last_pop  = t;
            end
            if (io_valid) begin
                if (m_sz < DEPTH || m_pop) q.push_back(io_data);
                else ovf_m = 1'b1;
            end
        end
    end

    // Monitor: status flags every cycle, and a UART receiver checking every frame cycle.
    bit     rx_active = 1'b0;
    int     rx_pos;
    int     rx_b;
    int     rx_exp;
    frame_t cur;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else begin
            chk("fifo_count", int'(fifo_count), q.size());
            chk("busy", int'(busy), int'((q.size() != 0) || (t < last_pop + FRAME)));
            chk("overflow", int'(overflow), int'(ovf_m));
            if (rx_active) begin
                rx_pos++;
                rx_b = rx_pos / C;
                if (rx_b == 0)      rx_exp = 0;
                else if (rx_b == 9) rx_exp = 1;
                else                rx_exp = int'(cur.data[rx_b-1]);
                chk("tx_bit", int'(tx), rx_exp);
                if (rx_pos == FRAME - 1) rx_active = 1'b0;
            end else if (tx == 1'b0) begin
                if (frame_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL spurious_start at cycle %0d: got tx=0 expected 1", t);
                end else begin
                    cur = frame_q.pop_front();
                    chk("start_cycle", t, cur.start);
                    rx_active = 1'b1;
                    rx_pos    = 0;
                end
            end else if (frame_q.size() != 0 && frame_q[0].start < t) begin
                n_checks++;
                n_err++;
                $display("FAIL missing_start at cycle %0d: got tx=1 expected 0", t);
                void'(frame_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d);
        io_valid = v;
        io_data  = d;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        io_valid = 1'b0;
        while (!(q.size() == 0 && frame_q.size() == 0 && t >= last_pop + FRAME && !rx_active)
               && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk("drain_timeout", k, 0);
    endtask

    task automatic do_reset();
        io_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nb;
        rst_n    = 1'b0;
        io_valid = 1'b0;
        io_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_count", int'(fifo_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0x41 from idle
        drive(1'b1, 8'h41);
        chk("single_busy_rise", int'(busy), 1);
        chk("single_tx_still_idle", int'(tx), 1);
        drive(1'b0, 8'h00);
        chk("single_tx_fall", int'(tx), 0);
        wait_idle(200);
        chk("single_busy_end", int'(busy), 0);

        // Back-to-back frames
        drive(1'b1, 8'h48);
        drive(1'b1, 8'h69);
        drive(1'b0, 8'h00);
        wait_idle(300);

        // Fill to 16 mid-frame, then strobe exactly at the stop-bit pop edge
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 8'($urandom));
        io_valid = 1'b0;
        chk("full_count", int'(fifo_count), DEPTH);
        k = 0;
        while (t + 1 != last_pop + FRAME && k < 200) begin
            drive(1'b0, 8'h00);
            k++;
        end
        drive(1'b1, 8'hAA);
        chk("full_pop_count", int'(fifo_count), DEPTH);
        chk("full_pop_overflow", int'(overflow), 0);
        drive(1'b0, 8'h00);
        wait_idle(1500);

        // Overflow: 18 strobes, the last is dropped
        for (int i = 0; i < 18; i++) drive(1'b1, 8'(i));
        chk("ovf_set", int'(overflow), 1);
        wait_idle(1500);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset mid-frame with 3 bytes queued
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i));
        repeat (10) drive(1'b0, 8'h00);
        chk("pre_reset_count", int'(fifo_count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_tx", int'(tx), 1);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_count", int'(fifo_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 8'h55);
        drive(1'b0, 8'h00);
        wait_idle(200);

        // Random soak with bursts that overrun the FIFO
        do_reset();
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) nb = $urandom_range(5, 20);
            else nb = 1;
            for (int j = 0; j < nb; j++) drive(1'b1, 8'($urandom));
            k = $urandom_range(0, 60);
            for (int j = 0; j < k; j++) drive(1'b0, 8'h00);
        end
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_uart_tx.md
# riscv_uart_tx

Serial console transmitter sitting directly downstream of the data-memory print port. It consumes the one-cycle `io_valid`/`io_data` character pulses produced by stores to address 0x8000_0000. It buffers them in a small FIFO, because the producer has no backpressure, and serialises each byte as 8N1 UART on `tx`. It replaces the testbench-side character sniffer, so silicon and FPGA builds get a real console pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 16: buffered characters. Must be a power of 2 and ≥ 2.
- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `io_valid`  in  1: one-cycle strobe. A new character is present on `io_data`.
- `io_data`  in  8: character, sampled when `io_valid`=1.
- `tx`  out  1: UART serial line. Idle-high, registered.
- `busy`  out  1: high while the FIFO is non-empty or a frame is in flight.
- `overflow`  out  1: sticky. Set when a character was dropped because the FIFO was full.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Reset values while `rst_n`=0, applied asynchronously:
  - `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
  - FIFO emptied, FSM in IDLE, baud counter and bit index cleared.
- Push rule: `io_valid`=1 pushes `io_data` if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is discarded and `overflow` is set. `overflow` is cleared only by reset.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged, including when the FIFO is full.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty: pop the head into an 8-bit shift register, load the baud counter with CLKS_PER_BIT-1, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
    - At its end, if the FIFO is non-empty: pop and go directly to START, giving back-to-back frames with no extra idle.
    - Otherwise go to IDLE.
- Baud counter: counts down from CLKS_PER_BIT-1 to 0. It reloads on every bit boundary. Width is $clog2(CLKS_PER_BIT).
- `tx` is driven from a flop, not decoded combinationally from state.
- Reset mid-frame: `tx` returns high immediately and the partially sent byte and all FIFO contents are lost.

## Timing
- `io_valid` sampled at edge N → `fifo_count` increments after edge N.
- FSM pops at edge N+1 → `tx` falls after edge N+1, i.e. 2 clocks after the strobe when idle.
- Each frame is exactly 10×CLKS_PER_BIT cycles.
- Back-to-back frames: the stop bit lasts exactly CLKS_PER_BIT cycles and is followed immediately by the next start bit.
- `busy` is combinational: (state≠IDLE) | (`fifo_count`≠0). It rises the cycle after the accepted strobe.
- With one frame in flight, the block absorbs FIFO_DEPTH+1 consecutive strobes from idle. Strobe FIFO_DEPTH+2 overflows.

## Structure
- Package `riscv_uart_pkg`:
  - FSM state enum `uart_tx_state_t` (IDLE, START, DATA, STOP).
  - `UART_DATA_BITS`=8.
  - Print-port address constant 32'h8000_0000, shared with the memory/IO decoder.
- Sub-module `riscv_uart_fifo`:
  - Parameterised synchronous FIFO (width 8, depth FIFO_DEPTH).
  - Push/pop, full/empty, and count outputs; pointer wrap via an extra MSB.
  - Reused later for an RX path.
- The top level holds the FSM, baud counter, shift register and overflow flag.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=16.
- Single byte: pulse `io_valid` with 0x41 from idle.
  - `tx` falls 2 clocks later.
  - It then holds 0,1,0,0,0,0,0,1,0,1, each value for 4 cycles (40 cycles total).
  - `busy` is high throughout, and low the cycle after the stop bit ends.
- Back-to-back: strobe 0x48 then 0x69 on consecutive cycles.
  - Two frames are sent with no gap: the stop bit lasts 4 cycles, then the start bit of 0x69 follows.
  - Total 80 cycles; `fifo_count` sequence is 1,1,0.
- Overflow: 18 strobes on consecutive cycles carrying 0x00..0x11.
  - The first 17 are transmitted in order.
  - 0x11 is dropped, `overflow`=1 from the cycle after strobe 18, and it stays set after the FIFO drains.
- Full plus simultaneous pop: fill to `fifo_count`=16 mid-frame, then strobe 0xAA in the same cycle the FSM pops at the end of a stop bit.
  - 0xAA is accepted, `fifo_count` stays 16, and `overflow` stays 0.
- Reset mid-frame: assert `rst_n`=0 during DATA with 3 bytes queued.
  - `tx`=1, `busy`=0 and `fifo_count`=0 immediately, without waiting for a clock edge.
  - After release, a new strobe of 0x55 is transmitted correctly.
- Random soak: a UART receiver model decodes random bytes and random strobe gaps.
  - The output must match the accepted input stream exactly.
  - Scoreboard the dropped bytes against `overflow`.
